lcd_timing_gen: RTL and testbench



---
 rtl/lcd_timing_pkg.sv | 37 +++
 rtl/lcd_timing_gen.sv | 115 +++++++++++
 tb/tb_lcd_timing_gen.sv | 230 +++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_timing_pkg.sv
// Shared 480x272 panel geometry so the generator and the downstream overlay
// stages agree on line/frame layout.
package lcd_timing_pkg;

    localparam int LCD_CNT_W    = 10;
    localparam int LCD_CNT_MAX  = 1 << LCD_CNT_W;

    localparam int LCD_H_ACTIVE = 480;
    localparam int LCD_H_FP     = 2;
    localparam int LCD_H_SYNC   = 41;
    localparam int LCD_H_BP     = 2;

    localparam int LCD_V_ACTIVE = 272;
    localparam int LCD_V_FP     = 2;
    localparam int LCD_V_SYNC   = 10;
    localparam int LCD_V_BP     = 2;

    localparam bit LCD_SYNC_POL = 1'b0;

    function automatic int span_total(input int sync_w, input int bp_w,
                                      input int act_w, input int fp_w);
        return sync_w + bp_w + act_w + fp_w;
    endfunction

    localparam int LCD_H_TOTAL = span_total(LCD_H_SYNC, LCD_H_BP, LCD_H_ACTIVE, LCD_H_FP);
    localparam int LCD_V_TOTAL = span_total(LCD_V_SYNC, LCD_V_BP, LCD_V_ACTIVE, LCD_V_FP);

    // One pipeline stage worth of decoded timing; sync flags are "active", not pin level.
    typedef struct packed {
        logic                 de;
        logic                 hs_act;
        logic                 vs_act;
        logic [LCD_CNT_W-1:0] x;
        logic [LCD_CNT_W-1:0] y;
    } lcd_stage_t;

endpackage

// File: rtl/lcd_timing_gen.sv
// LCD raster source: h/v counters, active-area decode, and a two-stage pipeline
// giving a request stream one clock ahead of the hs/vs/de/x/y output stream.
module lcd_timing_gen
    import lcd_timing_pkg::*;
#(
    parameter int H_ACTIVE = LCD_H_ACTIVE,
    parameter int H_FP     = LCD_H_FP,
    parameter int H_SYNC   = LCD_H_SYNC,
    parameter int H_BP     = LCD_H_BP,
    parameter int V_ACTIVE = LCD_V_ACTIVE,
    parameter int V_FP     = LCD_V_FP,
    parameter int V_SYNC   = LCD_V_SYNC,
    parameter int V_BP     = LCD_V_BP,
    parameter bit SYNC_POL = LCD_SYNC_POL
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 en,
    output logic                 req_de,
    output logic [LCD_CNT_W-1:0] req_x,
    output logic [LCD_CNT_W-1:0] req_y,
    output logic                 out_hs,
    output logic                 out_vs,
    output logic                 out_de,
    output logic [LCD_CNT_W-1:0] x_out,
    output logic [LCD_CNT_W-1:0] y_out,
    output logic                 frame_start
);

    localparam int H_TOTAL = span_total(H_SYNC, H_BP, H_ACTIVE, H_FP);
    localparam int V_TOTAL = span_total(V_SYNC, V_BP, V_ACTIVE, V_FP);
    localparam int H_START = H_SYNC + H_BP;
    localparam int H_END   = H_START + H_ACTIVE;
    localparam int V_START = V_SYNC + V_BP;
    localparam int V_END   = V_START + V_ACTIVE;

    generate
        if (H_TOTAL > LCD_CNT_MAX || V_TOTAL > LCD_CNT_MAX) begin : g_bad_geometry
            $error("lcd_timing_gen: H_TOTAL/V_TOTAL exceed 10-bit counter range");
        end
    endgenerate

    logic [LCD_CNT_W-1:0] r_hcnt;
    logic [LCD_CNT_W-1:0] r_vcnt;
    logic                 w_h_wrap;
    logic                 w_v_wrap;

    assign w_h_wrap = (r_hcnt == LCD_CNT_W'(H_TOTAL - 1));
    assign w_v_wrap = (r_vcnt == LCD_CNT_W'(V_TOTAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_hcnt <= '0;
            r_vcnt <= '0;
        end else if (en) begin
            if (w_h_wrap) begin
                r_hcnt <= '0;
                r_vcnt <= w_v_wrap ? '0 : r_vcnt + 1'b1;
            end else begin
                r_hcnt <= r_hcnt + 1'b1;
            end
        end
    end

    // Compare in 11 bits so an end bound of exactly 1024 stays representable.
    logic [LCD_CNT_W:0] w_hcnt_ext;
    logic [LCD_CNT_W:0] w_vcnt_ext;
    logic               w_h_in;
    logic               w_v_in;
    lcd_stage_t         w_s1_next;

    assign w_hcnt_ext = {1'b0, r_hcnt};
    assign w_vcnt_ext = {1'b0, r_vcnt};
    assign w_h_in = (w_hcnt_ext >= (LCD_CNT_W+1)'(H_START)) && (w_hcnt_ext < (LCD_CNT_W+1)'(H_END));
    assign w_v_in = (w_vcnt_ext >= (LCD_CNT_W+1)'(V_START)) && (w_vcnt_ext < (LCD_CNT_W+1)'(V_END));

    always_comb begin
        w_s1_next        = '0;
        w_s1_next.de     = w_h_in && w_v_in;
        w_s1_next.hs_act = (w_hcnt_ext < (LCD_CNT_W+1)'(H_SYNC));
        w_s1_next.vs_act = (w_vcnt_ext < (LCD_CNT_W+1)'(V_SYNC));
        if (w_s1_next.de) begin
            w_s1_next.x = r_hcnt - LCD_CNT_W'(H_START);
            w_s1_next.y = r_vcnt - LCD_CNT_W'(V_START);
        end
    end

    lcd_stage_t r_s1;
    lcd_stage_t r_s2;
    logic       r_frame_start;

    // Pipeline advances only with en so a stall freezes every output in place.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1          <= '0;
            r_s2          <= '0;
            r_frame_start <= 1'b0;
        end else if (en) begin
            r_s1          <= w_s1_next;
            r_s2          <= r_s1;
            r_frame_start <= r_s1.de && (r_s1.x == '0) && (r_s1.y == '0);
        end
    end

    assign req_de      = r_s1.de;
    assign req_x       = r_s1.x;
    assign req_y       = r_s1.y;
    assign out_de      = r_s2.de;
    assign x_out       = r_s2.x;
    assign y_out       = r_s2.y;
    assign frame_start = r_frame_start;
    assign out_hs      = SYNC_POL ? r_s2.hs_act : ~r_s2.hs_act;
    assign out_vs      = SYNC_POL ? r_s2.vs_act : ~r_s2.vs_act;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: full-size panel for first-pixel latency and async
// reset, plus a shrunken active-high geometry for whole-frame scoreboarding.
module tb_lcd_timing_gen;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, exp);
        end
    endtask

    // ---------------- DUT A: default 480x272, active-low sync ----------------
    logic       rst_a, en_a;
    logic       a_req_de, a_out_hs, a_out_vs, a_out_de, a_fs;
    logic [9:0] a_req_x, a_req_y, a_x_out, a_y_out;

    lcd_timing_gen u_dut_a (
        .clk(clk), .rst_n(rst_a), .en(en_a),
        .req_de(a_req_de), .req_x(a_req_x), .req_y(a_req_y),
        .out_hs(a_out_hs), .out_vs(a_out_vs), .out_de(a_out_de),
        .x_out(a_x_out), .y_out(a_y_out), .frame_start(a_fs)
    );

    // ---------------- DUT B: 8x5 active, totals 15x9, active-high sync -------
    logic       rst_b, en_b;
    logic       b_req_de, b_out_hs, b_out_vs, b_out_de, b_fs;
    logic [9:0] b_req_x, b_req_y, b_x_out, b_y_out;

    lcd_timing_gen #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(5), .V_FP(1), .V_SYNC(2), .V_BP(1),
        .SYNC_POL(1'b1)
    ) u_dut_b (
        .clk(clk), .rst_n(rst_b), .en(en_b),
        .req_de(b_req_de), .req_x(b_req_x), .req_y(b_req_y),
        .out_hs(b_out_hs), .out_vs(b_out_vs), .out_de(b_out_de),
        .x_out(b_x_out), .y_out(b_y_out), .frame_start(b_fs)
    );

    // 1-cycle ROM addressed by the request stream
    function automatic logic [15:0] rom_f(input logic [9:0] x, input logic [9:0] y);
        return 16'(y * 37 + x * 3 + 90);
    endfunction

    logic [15:0] rom_b = '0;
    always @(posedge clk) rom_b <= rom_f(b_req_x, b_req_y);

    int   cyc = 0;
    int   ecyc = 0;
    logic en_at_edge = 1'b0;
    always @(posedge clk) begin
        cyc++;
        en_at_edge = en_b;
        if (en_b) ecyc++;
    end

    // ---------------- scoreboard for DUT B ----------------
    logic [19:0] exp_q[$];
    logic        mon_b_on = 1'b0;
    logic        snap_valid = 1'b0;
    logic [44:0] snap;
    logic        seen_de = 1'b0;
    logic        prev_hs = 1'b0, prev_vs = 1'b0, prev_de = 1'b0;
    int          hs_rise = -1, vs_rise = -1, hs_start = 0, vs_start = 0;
    int          de_run = 0, de_cnt = 0, n_fs = 0, last_fs = 0;
    logic [19:0] pix;

    function automatic logic [44:0] b_vec();
        return {b_req_de, b_req_x, b_req_y, b_out_hs, b_out_vs, b_out_de, b_x_out, b_y_out, b_fs};
    endfunction

    always @(negedge clk) begin
        if (mon_b_on && en_at_edge) begin
            if (b_fs) begin
                if (n_fs > 0) begin
                    check("b_frame_period", 64'(cyc - last_fs), (n_fs == 2) ? 64'd155 : 64'd135);
                    check("b_de_per_frame", 64'(de_cnt), 64'd40);
                end
                de_cnt  = 0;
                last_fs = cyc;
                n_fs++;
            end
            if (b_out_de) begin
                if (!seen_de) begin
                    seen_de = 1'b1;
                    check("b_first_de_ecyc", 64'(ecyc), 64'd52);
                end
                if (exp_q.size() == 0) begin
                    check("b_queue_underflow", 64'(exp_q.size()), 64'd1);
                end else begin
                    pix = exp_q.pop_front();
                    check("b_x_out", 64'(b_x_out), 64'(pix[9:0]));
                    check("b_y_out", 64'(b_y_out), 64'(pix[19:10]));
                    check("b_frame_start", 64'(b_fs), 64'(pix == 20'd0));
                    check("b_rom_align", 64'(rom_b), 64'(rom_f(pix[9:0], pix[19:10])));
                end
                de_run++;
                de_cnt++;
            end else begin
                check("b_idle_xy_fs", 64'({b_fs, b_x_out, b_y_out}), 64'd0);
                if (prev_de) begin
                    check("b_de_run", 64'(de_run), 64'd8);
                    de_run = 0;
                end
            end
            if (b_out_hs && !prev_hs) begin
                if (hs_rise >= 0) check("b_hs_period", 64'(ecyc - hs_rise), 64'd15);
                hs_rise  = ecyc;
                hs_start = ecyc;
            end else if (!b_out_hs && prev_hs) begin
                check("b_hs_width", 64'(ecyc - hs_start), 64'd3);
            end
            if (b_out_vs && !prev_vs) begin
                if (vs_rise >= 0) check("b_vs_period", 64'(ecyc - vs_rise), 64'd135);
                vs_rise  = ecyc;
                vs_start = ecyc;
            end else if (!b_out_vs && prev_vs) begin
                check("b_vs_width", 64'(ecyc - vs_start), 64'd30);
            end
            prev_hs    = b_out_hs;
            prev_vs    = b_out_vs;
            prev_de    = b_out_de;
            snap       = b_vec();
            snap_valid = 1'b1;
        end else if (mon_b_on && snap_valid) begin
            check("b_frozen", 64'(b_vec()), 64'(snap));
        end
    end

    // ---------------- DUT A driver ----------------
    task automatic a_run_first_pixel();
        int req_rise = 0;
        int de_rise = 0;
        int stop_n = 0;
        for (int n = 1; n <= 7000; n++) begin
            @(posedge clk);
            @(negedge clk);
            if (n == 42)   check("a_hs_active_last", 64'(a_out_hs), 64'd0);
            if (n == 43)   check("a_hs_inactive", 64'(a_out_hs), 64'd1);
            if (n == 5251) check("a_vs_active_last", 64'(a_out_vs), 64'd0);
            if (n == 5252) check("a_vs_inactive", 64'(a_out_vs), 64'd1);
            if (a_req_de && req_rise == 0) begin
                req_rise = n;
                check("a_req_first_xy", 64'({a_req_x, a_req_y}), 64'd0);
            end
            if (a_out_de && de_rise == 0) begin
                de_rise = n;
                check("a_first_xy", 64'({a_x_out, a_y_out}), 64'd0);
                check("a_first_fs", 64'(a_fs), 64'd1);
            end else if (de_rise != 0 && n == de_rise + 1) begin
                check("a_fs_one_cycle", 64'(a_fs), 64'd0);
                check("a_second_x", 64'(a_x_out), 64'd1);
            end
            if (de_rise != 0 && a_out_de && a_x_out == 10'd300) begin
                stop_n = n;
                break;
            end
        end
        check("a_req_rise_cycle", 64'(req_rise), 64'd6344);
        check("a_de_rise_cycle", 64'(de_rise), 64'd6345);
        check("a_x300_cycle", 64'(stop_n), 64'd6645);
    endtask

    initial begin
        rst_a = 1'b0; en_a = 1'b0;
        rst_b = 1'b0; en_b = 1'b0;
        repeat (3) @(negedge clk);
        check("a_reset_state", 64'({a_req_de, a_out_de, a_fs, a_out_hs, a_out_vs, a_x_out, a_y_out, a_req_x}), 64'({5'b00011, 30'd0}));
        check("b_reset_state", 64'({b_req_de, b_out_de, b_fs, b_out_hs, b_out_vs, b_x_out, b_y_out}), 64'd0);

        // DUT A: first-pixel latency, then async reset mid-active and repeat
        rst_a = 1'b1; en_a = 1'b1;
        a_run_first_pixel();
        #2 rst_a = 1'b0;
        #1;
        check("a_async_de", 64'(a_out_de), 64'd0);
        check("a_async_sync", 64'({a_out_hs, a_out_vs}), 64'd3);
        check("a_async_rest", 64'({a_req_de, a_fs, a_x_out, a_y_out, a_req_x, a_req_y}), 64'd0);
        @(negedge clk);
        rst_a = 1'b1;
        a_run_first_pixel();
        en_a = 1'b0;

        // DUT B: three frames of expected pixels, stall 20 clocks mid-line in frame 2
        for (int f = 0; f < 3; f++)
            for (int y = 0; y < 5; y++)
                for (int x = 0; x < 8; x++)
                    exp_q.push_back({10'(y), 10'(x)});
        @(negedge clk);
        rst_b = 1'b1; en_b = 1'b1; mon_b_on = 1'b1;
        begin
            int found = 0;
            for (int k = 0; k < 2000; k++) begin
                @(negedge clk);
                if (n_fs == 2 && b_out_de && b_x_out == 10'd5 && b_y_out == 10'd2) begin
                    found = 1;
                    break;
                end
            end
            check("b_stall_point_found", 64'(found), 64'd1);
        end
        en_b = 1'b0;
        repeat (20) @(negedge clk);
        en_b = 1'b1;
        for (int k = 0; k < 2000; k++) begin
            @(negedge clk);
            if (exp_q.size() == 0) break;
        end
        repeat (20) @(negedge clk);
        check("b_queue_drained", 64'(exp_q.size()), 64'd0);
        check("b_frames_seen", 64'(n_fs), 64'd3);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
